// File: rtl/calculator_pkg.sv
// Shared digit type, sizes and active-low seven-segment encodings
// for the calculator display path.
package calculator_pkg;

    localparam int DIGITS = 4;
    localparam int VAL_W  = 14;
    localparam logic [VAL_W-1:0] MAX_SHOWN = 14'd9999;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    typedef struct packed {
        bcd_t [DIGITS-1:0] digit;
        logic              over;
    } bcd_result_t;

    // Bit order {g,f,e,d,c,b,a}, 0 lights a segment
    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_E     = 7'h06;
    localparam seg_t SEG_R     = 7'h2F;
    localparam seg_t SEG_DASH  = 7'h3F;
    localparam seg_t SEG_BLANK = 7'h7F;

    function automatic seg_t seg_of(bcd_t d);
        seg_t s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic seg_t err_seg(logic [1:0] idx);
        seg_t s;
        case (idx)
            2'd3:    s = SEG_E;
            2'd2:    s = SEG_R;
            2'd1:    s = SEG_R;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/calculator_bin2bcd.sv
// Sequential double-dabble: one shift per cycle, VAL_W cycles per value.
// Result registers only change when a conversion completes.
module calculator_bin2bcd
    import calculator_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] value,
    output logic             busy,
    output bcd_result_t      res
);

    localparam logic [3:0] LAST_STEP = 4'(VAL_W - 1);

    logic [VAL_W-1:0]    bin_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [4*DIGITS-1:0] bcd_nxt;
    logic [3:0]          step_q;
    logic                over_q;
    logic                busy_q;
    bcd_result_t         res_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] > 4'd4)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    assign bcd_nxt = {bcd_adj[4*DIGITS-2:0], bin_q[VAL_W-1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            step_q <= '0;
            over_q <= 1'b0;
            busy_q <= 1'b0;
            res_q  <= '0;
        end else if (busy_q) begin
            bin_q  <= bin_q << 1;
            bcd_q  <= bcd_nxt;
            step_q <= step_q + 4'd1;
            if (step_q == LAST_STEP) begin
                busy_q      <= 1'b0;
                res_q.digit <= bcd_nxt;
                res_q.over  <= over_q;
            end
        end else if (start) begin
            bin_q  <= value;
            bcd_q  <= '0;
            step_q <= '0;
            over_q <= (value > MAX_SHOWN);
            busy_q <= 1'b1;
        end
    end

    assign busy = busy_q;
    assign res  = res_q;

endmodule

// File: rtl/calculator_output.sv
// Four-digit multiplexed seven-segment driver for calculator results.
// Define CALC_OUTPUT_BLANK_EN to blank leading zero digits.
module calculator_output
    import calculator_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] value_in,
    input  logic             value_valid,
    input  logic             error_in,
    output logic             busy,
    output logic [6:0]       seg,
    output logic [3:0]       an
);

`ifdef CALC_OUTPUT_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(REFRESH_DIV - 1);

    bcd_result_t      res;
    logic [CNT_W-1:0] tick_q;
    logic [1:0]       idx_q;
    bcd_t             cur;
    logic             z1, z2, z3;
    logic             lead_zero;
    logic             show_err, show_dash, show_blank, show_digit;
    seg_t             seg_d;
    logic [3:0]       an_d;

    calculator_bin2bcd u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (value_valid & ~busy),
        .value (value_in),
        .busy  (busy),
        .res   (res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q <= '0;
            idx_q  <= 2'd0;
        end else if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            idx_q  <= idx_q + 2'd1;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

    assign cur = res.digit[idx_q];
    assign z3  = (res.digit[3] == 4'd0);
    assign z2  = z3 && (res.digit[2] == 4'd0);
    assign z1  = z2 && (res.digit[1] == 4'd0);

    // Digit 0 is never a leading zero, so a zero value still shows "0"
    always_comb begin
        lead_zero = 1'b0;
        case (idx_q)
            2'd1:    lead_zero = z1;
            2'd2:    lead_zero = z2;
            2'd3:    lead_zero = z3;
            default: lead_zero = 1'b0;
        endcase
    end

    assign show_err   = error_in;
    assign show_dash  = ~error_in & res.over;
    assign show_blank = ~error_in & ~res.over & BLANK_EN & lead_zero;
    assign show_digit = ~show_err & ~show_dash & ~show_blank;

    always_comb begin
        seg_d = SEG_BLANK;
        unique case (1'b1)
            show_err:   seg_d = err_seg(idx_q);
            show_dash:  seg_d = SEG_DASH;
            show_blank: seg_d = SEG_BLANK;
            show_digit: seg_d = seg_of(cur);
            default:    seg_d = SEG_BLANK;
        endcase
    end

    assign an_d = ~(4'b0001 << idx_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= SEG_BLANK;
            an  <= 4'hF;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_calculator_output.sv
// Scoreboard bench for calculator_output with a fast refresh divider.
// Expected digits come from decimal arithmetic on the loaded value.
module tb_calculator_output;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] value_in = '0;
    logic        value_valid = 1'b0;
    logic        error_in = 1'b0;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    calculator_output #(.REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .reset       (reset),
        .value_in    (value_in),
        .value_valid (value_valid),
        .error_in    (error_in),
        .busy        (busy),
        .seg         (seg),
        .an          (an)
    );

    always #5 clk = ~clk;

`ifdef CALC_OUTPUT_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    function automatic logic [6:0] digit_pat(int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(int v, bit err, int i);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (err) begin
            if (i == 3) return 7'h06;
            if (i == 0) return 7'h7F;
            return 7'h2F;
        end
        if (v > 9999) return 7'h3F;
        if (BLANK && i > 0 && v < p) return 7'h7F;
        return digit_pat((v / p) % 10);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_scan(int v, bit err, string tag);
        logic [6:0] got[4];
        for (int i = 0; i < 4; i++) got[i] = 'x;
        @(negedge clk);
        repeat (16) begin
            @(negedge clk);
            case (an)
                4'b1110: got[0] = seg;
                4'b1101: got[1] = seg;
                4'b1011: got[2] = seg;
                4'b0111: got[3] = seg;
                default: begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s_an: got %b expected one-hot-low", tag, an);
                end
            endcase
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_v%0d_d%0d", tag, v, i), got[i],
                  exp_seg(v, err, i));
    endtask

    // Reference: a load is taken only when no conversion window is open
    initial begin : model
        int left;
        left = 0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                left = 0;
                exp_q.delete();
            end else if (left > 0) begin
                left--;
            end else if (value_valid) begin
                exp_q.push_back(int'(value_in));
                left = 14;
            end
        end
    end

    initial begin : monitor
        logic pb;
        int   run;
        int   v;
        pb  = 1'b0;
        run = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pb  = 1'b0;
                run = 0;
            end else begin
                if (busy) begin
                    run++;
                end else if (pb) begin
                    check("busy_len", run, 14);
                    run = 0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: got busy fall expected none");
                    end else begin
                        v = exp_q.pop_front();
                        check_scan(v, error_in, "conv");
                    end
                end
                pb = busy;
            end
        end
    end

    task automatic load(int v);
        @(negedge clk);
        value_in    = 14'(v);
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: got busy stuck expected fall");
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int v;
        repeat (10) begin
            @(negedge clk);
            check("rst_seg", seg, 7'h7F);
            check("rst_an", an, 4'hF);
            check("rst_busy", busy, 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("first_an", an, 4'b1110);
        check("first_seg", seg, 7'h40);
        repeat (3) begin
            @(negedge clk);
            check("hold_an", an, 4'b1110);
        end
        @(negedge clk);
        check("adv_an", an, 4'b1101);

        load(1234);
        wait_idle();
        load(10000);
        wait_idle();
        load(5);
        wait_idle();

        load(42);
        repeat (3) @(negedge clk);
        load(9999);
        wait_idle();

        load(777);
        repeat (4) @(negedge clk);
        error_in = 1'b1;
        wait_idle();
        error_in = 1'b0;
        check_scan(777, 1'b0, "err_clear");

        load(4321);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_an", an, 4'hF);
        check("abort_seg", seg, 7'h7F);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_scan(0, 1'b0, "post_rst");
        load(606);
        wait_idle();

        repeat (12) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 9);
                1:       v = $urandom_range(0, 9999);
                2:       v = $urandom_range(10000, 16383);
                default: v = $urandom_range(0, 999);
            endcase
            load(v);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                load($urandom_range(0, 16383));
            end
            wait_idle();
        end

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calculator_output.md
CALCULATOR_OUTPUT -- requirements
Module: calculator_output

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit stays enabled before the scan advances (legal range 2..2^20).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-004 SHALL have port value_in, input, 14, unsigned binary result to display.
REQ-005 SHALL have port value_valid, input, 1, one-cycle load strobe for value_in.
REQ-006 SHALL have port error_in, input, 1, level; while high the display shows "Err".
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-009 SHALL have port an, output, 4, active-low digit enables; an[3] is the leftmost digit.

Function
REQ-010 SHALL latch value_in on a cycle with value_valid=1 and busy=0, then assert busy from the next cycle.
REQ-011 SHALL convert with sequential double-dabble, one shift per cycle, 14 cycles; busy stays high exactly 14 cycles.
REQ-012 SHALL update the four displayed BCD digits in the cycle busy falls; digits hold their old value during conversion.
REQ-013 SHALL ignore value_valid while busy=1; no queuing.
REQ-014 SHALL, for a latched value > 9999, display "----" (segment g only on all digits) instead of BCD digits.
REQ-015 SHALL run a refresh counter 0..REFRESH_DIV-1; on wrap to 0 the digit index advances 0->1->2->3->0.
REQ-016 SHALL drive an as one-hot-low for the current digit index (index 0 -> an=4'b1110) and seg with that digit's pattern, both registered together, with no cycle where two digits are enabled.
REQ-017 SHALL, while error_in=1, show E, r, r, blank on digits 3..0, overriding numeric and "----" content; the conversion is unaffected.
REQ-018 SHALL accept value_valid in the cycle busy falls only from the following cycle on (busy is sampled as 1 in the falling cycle).

Reset
REQ-019 SHALL, on reset=0, immediately force seg=7'h7F, an=4'hF, busy=0, refresh counter=0, digit index=0, stored digits=0.
REQ-020 SHALL abort any conversion on reset mid-operation; stored digits read 0000 after release.
REQ-021 SHALL enable the first digit (an=4'b1110) on the first clock edge after reset release, showing "0".

Configuration
REQ-022 SHALL, with macro CALC_OUTPUT_BLANK_EN defined, blank leading zero digits (digit 0 always shown, so 0 shows as "   0"); without it all four digits are always shown ("0000").
REQ-023 SHALL not apply blanking to "----" or "Err" content.

Structure
REQ-024 SHALL take the seven-segment encodings (0-9, E, r, dash, blank) and the 4-bit BCD digit typedef from shared package calculator_pkg.
REQ-025 SHALL place the double-dabble converter in sub-module calculator_bin2bcd (start/value in, busy/four BCD digits out); scan and segment logic stay in calculator_output.

Verification (REFRESH_DIV=4)
REQ-026 Reset held 10 cycles, released -> seg=7'h7F and an=4'hF during reset; an=4'b1110, seg="0" after release; index advances every 4 cycles.
REQ-027 value_in=1234 pulse -> busy high 14 cycles; afterwards scan shows 4,3,2,1 on an=1110,1101,1011,0111.
REQ-028 value_in=10000 -> all digits show dash pattern; then value_in=5 with CALC_OUTPUT_BLANK_EN -> "   5", without -> "0005".
REQ-029 value_valid=9999 during busy of prior load 42 -> 9999 ignored; display 42.
REQ-030 error_in=1 mid-conversion of 777 -> "Err " shown; busy still falls after 14 cycles; error_in=0 -> "777" with blanking, "0777" without.
REQ-031 reset=0 asserted 5 cycles into conversion -> busy=0 at once; after release, display shows 0 and a new load converts normally.
